// File: rtl/sram_pkg.sv
// Shared types and sizes for the 32-bit LSU to 16-bit asynchronous SRAM controller.
package sram_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 18;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } half_e;

  // Byte enables {upper, lower} of the 32-bit store mask that belong to one halfword.
  function automatic logic [1:0] lane_mask(input logic [3:0] bmask, input half_e half);
    return (half == HI) ? bmask[3:2] : bmask[1:0];
  endfunction

endpackage

// File: rtl/sram_io_buf.sv
// Tristate pad driver for the bidirectional SRAM data bus.
module sram_io_buf
  import sram_pkg::*;
(
  input  logic               oe_i,
  input  logic [SRAM_DW-1:0] dout_i,
  output logic [SRAM_DW-1:0] din_o,
  inout  wire  [SRAM_DW-1:0] io_pad
);

  assign io_pad = oe_i ? dout_i : {SRAM_DW{1'bz}};
  assign din_o  = io_pad;

endmodule

// File: rtl/sram_ctrl_32b.sv
// LSU responder: serialises one 32-bit load/store into low then high 16-bit SRAM accesses.
module sram_ctrl_32b
  import sram_pkg::*;
#(
  parameter int ACC_CYC = 2,
  parameter int AW      = 17
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic               i_wren,
  input  logic [AW-1:0]      i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic [31:0]        o_rdata,
  output logic               o_ack,
  output logic               o_stall,
  output logic [SRAM_AW-1:0] o_SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  localparam int CW = $clog2(ACC_CYC) + 1;

  state_e               state_q, state_d;
  half_e                half_q, half_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           bmask_q, bmask_d;
  logic                 wren_q, wren_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 active;
  logic                 strobe_last;
  logic [1:0]           lanes;
  logic                 dq_oe;
  logic [SRAM_DW-1:0]   dq_out;
  logic [SRAM_DW-1:0]   dq_in;

  assign active      = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign strobe_last = (cnt_q == CW'(ACC_CYC - 1));
  assign lanes       = lane_mask(bmask_q, half_q);

  // NOTE: every _d gets its current value first so no path through the case leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    wren_d  = wren_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req) begin
          addr_d  = i_addr;
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          wren_d  = i_wren;
          if (i_wren && (i_bmask == 4'b0000)) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            half_d  = (i_wren && (i_bmask[1:0] == 2'b00)) ? HI : LO;
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (strobe_last) begin
          state_d = HOLD;
          // The async SRAM has had the full strobe window to settle its output.
          if (!wren_q) begin
            if (half_q == HI) rdata_d[31:16] = dq_in;
            else              rdata_d[15:0]  = dq_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if ((half_q == LO) && (!wren_q || (bmask_q[3:2] != 2'b00))) begin
          state_d = SETUP;
          half_d  = HI;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others; the async reset drops strobes the instant rst_n falls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      half_q  <= LO;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      wren_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      wren_q  <= wren_d;
      rdata_q <= rdata_d;
    end
  end

  // Controls decode straight from registered state; address and lanes stay put across
  // SETUP/STROBE/HOLD, so only the strobes move inside an access.
  assign o_SRAM_ADDR = SRAM_AW'({addr_q, half_q});
  assign o_SRAM_CE_N = ~active;
  assign o_SRAM_WE_N = ~((state_q == STROBE) && wren_q);
  assign o_SRAM_OE_N = ~((state_q == STROBE) && !wren_q);
  assign o_SRAM_LB_N = ~active | (wren_q & ~lanes[0]);
  assign o_SRAM_UB_N = ~active | (wren_q & ~lanes[1]);

  assign dq_oe  = active & wren_q;
  assign dq_out = (half_q == HI) ? wdata_q[31:16] : wdata_q[15:0];

  assign o_ack   = (state_q == DONE);
  assign o_stall = i_req & ~o_ack;
  assign o_rdata = rdata_q;

  sram_io_buf u_io_buf (
    .oe_i   (dq_oe),
    .dout_i (dq_out),
    .din_o  (dq_in),
    .io_pad (io_SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_ctrl_32b.sv
// Bench for sram_ctrl_32b: SRAM fixture, transaction-level expected-waveform model, per-cycle compare.
module tb_sram_ctrl_32b;

  localparam int ACC_CYC = 2;
  localparam int AW      = 17;

  typedef struct packed {
    logic        ack;
    logic        ce_n;
    logic        we_n;
    logic        oe_n;
    logic        lb_n;
    logic        ub_n;
    logic [17:0] addr;
    logic        drv;
    logic [15:0] dq;
  } bus_t;

  typedef struct packed {
    bus_t        bus;
    logic        rd_chk;
    logic [31:0] rdata;
  } exp_t;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_req   = 1'b0;
  logic          i_wren  = 1'b0;
  logic [AW-1:0] i_addr  = '0;
  logic [31:0]   i_wdata = '0;
  logic [3:0]    i_bmask = '0;
  logic [31:0]   o_rdata;
  logic          o_ack;
  logic          o_stall;
  logic [17:0]   o_SRAM_ADDR;
  wire  [15:0]   io_SRAM_DQ;
  logic          o_SRAM_CE_N, o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          chk_en  = 1'b0;
  exp_t        exp_q[$];
  int          ack_log[$];
  logic [33:0] wr_log[$];
  logic [15:0] ref_mem[int];
  logic [15:0] sram_mem[int];
  logic [15:0] sram_rd_q = '0;
  logic [31:0] exp_rdata = '0;
  logic        sram_drv;

  always #5 i_clk = ~i_clk;

  sram_ctrl_32b #(.ACC_CYC(ACC_CYC), .AW(AW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_wren      (i_wren),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_bmask     (i_bmask),
    .o_rdata     (o_rdata),
    .o_ack       (o_ack),
    .o_stall     (o_stall),
    .o_SRAM_ADDR (o_SRAM_ADDR),
    .io_SRAM_DQ  (io_SRAM_DQ),
    .o_SRAM_CE_N (o_SRAM_CE_N),
    .o_SRAM_WE_N (o_SRAM_WE_N),
    .o_SRAM_OE_N (o_SRAM_OE_N),
    .o_SRAM_LB_N (o_SRAM_LB_N),
    .o_SRAM_UB_N (o_SRAM_UB_N)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Power-up content of any halfword never written.
  function automatic logic [15:0] init_pat(input logic [17:0] a);
    return {8'h00, a[7:0] ^ 8'h5A};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return init_pat(a);
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e          = '0;
    e.bus.ce_n = 1'b1;
    e.bus.we_n = 1'b1;
    e.bus.oe_n = 1'b1;
    e.bus.lb_n = 1'b1;
    e.bus.ub_n = 1'b1;
    return e;
  endfunction

  // Asynchronous SRAM fixture: reads present data while OE_N is low, writes lanes while WE_N is low.
  assign sram_drv   = !o_SRAM_CE_N && !o_SRAM_OE_N && o_SRAM_WE_N;
  assign io_SRAM_DQ = sram_drv ? sram_rd_q : 16'hzzzz;

  initial begin : sram_model
    logic [15:0] v;
    bit          we_low_prev;
    we_low_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!o_SRAM_CE_N && !o_SRAM_WE_N) begin
        v = sram_rd(o_SRAM_ADDR);
        if (!o_SRAM_LB_N) v[7:0]  = io_SRAM_DQ[7:0];
        if (!o_SRAM_UB_N) v[15:8] = io_SRAM_DQ[15:8];
        sram_mem[int'(o_SRAM_ADDR)] = v;
        if (!we_low_prev) wr_log.push_back({o_SRAM_ADDR, io_SRAM_DQ});
      end
      we_low_prev = !o_SRAM_WE_N;
      sram_rd_q   = sram_rd(o_SRAM_ADDR);
    end
  end

  initial begin : cycle_count
    forever begin
      @(posedge i_clk);
      cyc++;
    end
  end

  // One compare per cycle against the expected waveform; an empty schedule means idle bus.
  initial begin : compare_proc
    exp_t e;
    bus_t a;
    forever begin
      @(negedge i_clk);
      if (chk_en) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = idle_exp();
        a.ack  = o_ack;
        a.ce_n = o_SRAM_CE_N;
        a.we_n = o_SRAM_WE_N;
        a.oe_n = o_SRAM_OE_N;
        a.lb_n = o_SRAM_LB_N;
        a.ub_n = o_SRAM_UB_N;
        a.addr = o_SRAM_CE_N ? 18'h0 : o_SRAM_ADDR;
        a.drv  = dut.dq_oe;
        a.dq   = dut.dq_oe ? io_SRAM_DQ : 16'h0;
        if (o_ack) ack_log.push_back(cyc);
        check("bus", 64'(a), 64'(e.bus));
        check("stall", 64'(o_stall), 64'(i_req & ~e.bus.ack));
        check("dq_vs_oe", 64'(dut.dq_oe & ~o_SRAM_OE_N), 64'(0));
        if (e.rd_chk) check("ack_rdata", 64'(o_rdata), 64'(e.rdata));
      end
    end
  end

  // Update the word model and queue the expected waveform: the request cycle, then
  // setup + ACC_CYC strobe + hold per halfword touched, then the ack cycle.
  task automatic start_txn(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                           input logic [3:0] bm);
    exp_t        e;
    int          halves[$];
    int          h;
    logic [17:0] hw;
    logic [15:0] v;
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bm[b]) begin
          hw = {a, b[1]};
          v  = ref_rd(hw);
          if (b[0]) v[15:8] = wd[8*b +: 8];
          else      v[7:0]  = wd[8*b +: 8];
          ref_mem[int'(hw)] = v;
        end
      end
      if (bm[1:0] != 2'b00) halves.push_back(0);
      if (bm[3:2] != 2'b00) halves.push_back(1);
    end else begin
      exp_rdata = {ref_rd({a, 1'b1}), ref_rd({a, 1'b0})};
      halves    = '{0, 1};
    end
    exp_q.push_back(idle_exp());
    foreach (halves[k]) begin
      h          = halves[k];
      e          = idle_exp();
      e.bus.ce_n = 1'b0;
      e.bus.addr = {a, h[0]};
      e.bus.lb_n = wr ? ~bm[2*h]   : 1'b0;
      e.bus.ub_n = wr ? ~bm[2*h+1] : 1'b0;
      e.bus.drv  = wr;
      e.bus.dq   = wr ? ((h == 1) ? wd[31:16] : wd[15:0]) : 16'h0;
      exp_q.push_back(e);
      for (int s = 0; s < ACC_CYC; s++) begin
        e.bus.we_n = ~wr;
        e.bus.oe_n = wr;
        exp_q.push_back(e);
      end
      e.bus.we_n = 1'b1;
      e.bus.oe_n = 1'b1;
      exp_q.push_back(e);
    end
    e         = idle_exp();
    e.bus.ack = 1'b1;
    e.rd_chk  = 1'b1;
    e.rdata   = exp_rdata;
    exp_q.push_back(e);
    i_req   = 1'b1;
    i_wren  = wr;
    i_addr  = a;
    i_wdata = wd;
    i_bmask = bm;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge following the ack.
  task automatic do_txn(input string name, input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] bm, input int exp_lat,
                        input bit keep_req);
    int n0, c0;
    n0 = ack_log.size();
    start_txn(wr, a, wd, bm);
    c0 = cyc;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge i_clk);
    check({name, " timeout"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    #1;
    if (!keep_req) i_req = 1'b0;
    check({name, " ack_count"}, 64'(ack_log.size()), 64'(n0 + 1));
    if (ack_log.size() > n0) check({name, " latency"}, 64'(ack_log[n0] - c0), 64'(exp_lat));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int wl0;
    int na;

    #1 i_rst_n = 1'b0;
    #2;
    check("rst ctrl", 64'({o_SRAM_CE_N, o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N}),
          64'(5'h1F));
    check("rst addr", 64'(o_SRAM_ADDR), 64'(0));
    check("rst ack", 64'(o_ack), 64'(0));
    check("rst rdata", 64'(o_rdata), 64'(0));
    check("rst dq_oe", 64'(dut.dq_oe), 64'(0));
    idle(2);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;
    idle(1);

    // Full-word store, then read it back.
    wl0 = wr_log.size();
    do_txn("st_full", 1'b1, 17'h00010, 32'hDEADBEEF, 4'hF, 9, 1'b0);
    check("st_full writes", 64'(wr_log.size() - wl0), 64'(2));
    if (wr_log.size() >= wl0 + 2) begin
      check("st_full phase0", 64'(wr_log[wl0]),     64'({18'h00020, 16'hBEEF}));
      check("st_full phase1", 64'(wr_log[wl0 + 1]), 64'({18'h00021, 16'hDEAD}));
    end
    idle(2);
    do_txn("ld_full", 1'b0, 17'h00010, 32'h0, 4'h0, 9, 1'b0);
    check("ld_full rdata", 64'(o_rdata), 64'(32'hDEADBEEF));
    idle(1);

    // Single byte in the high half at the top address.
    wl0 = wr_log.size();
    do_txn("st_top", 1'b1, 17'h1FFFF, 32'h00AA0000, 4'b0100, 5, 1'b0);
    check("st_top writes", 64'(wr_log.size() - wl0), 64'(1));
    if (wr_log.size() > wl0) check("st_top phase", 64'(wr_log[wl0]), 64'({18'h3FFFF, 16'h00AA}));
    do_txn("ld_top", 1'b0, 17'h1FFFF, 32'h0, 4'hF, 9, 1'b0);
    check("ld_top rdata", 64'(o_rdata), 64'(32'h00AA00A4));

    // Empty mask: no SRAM cycle, rdata untouched.
    wl0 = wr_log.size();
    do_txn("st_empty", 1'b1, 17'h00020, 32'h12345678, 4'b0000, 1, 1'b0);
    check("st_empty writes", 64'(wr_log.size() - wl0), 64'(0));
    check("st_empty rdata", 64'(o_rdata), 64'(32'h00AA00A4));
    idle(3);

    // Partial byte lanes across both halves and a low-half-only store.
    do_txn("st_base", 1'b1, 17'h00030, 32'h11223344, 4'hF, 9, 1'b0);
    do_txn("st_1001", 1'b1, 17'h00030, 32'hAABBCCDD, 4'b1001, 9, 1'b0);
    do_txn("st_0011", 1'b1, 17'h00030, 32'h55556666, 4'b0011, 5, 1'b0);
    do_txn("ld_mix", 1'b0, 17'h00030, 32'h0, 4'h0, 9, 1'b0);
    check("ld_mix rdata", 64'(o_rdata), 64'(32'hAA226666));
    idle(2);

    // Back-to-back store then load with i_req held high throughout.
    do_txn("b2b_st", 1'b1, 17'h00040, 32'hCAFEF00D, 4'hF, 9, 1'b1);
    do_txn("b2b_ld", 1'b0, 17'h00040, 32'h0, 4'h0, 9, 1'b0);
    na = ack_log.size();
    if (na >= 2) check("b2b ack spacing", 64'(ack_log[na-1] - ack_log[na-2]), 64'(10));
    check("b2b rdata", 64'(o_rdata), 64'(32'hCAFEF00D));
    idle(2);

    // Reset during the first strobe of a store.
    na = ack_log.size();
    start_txn(1'b1, 17'h00100, 32'h01020304, 4'hF);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    check("pre_rst we_n", 64'(o_SRAM_WE_N), 64'(0));
    chk_en  = 1'b0;
    i_rst_n = 1'b0;
    i_req   = 1'b0;
    #1;
    check("mid_rst ce_we", 64'({o_SRAM_CE_N, o_SRAM_WE_N}), 64'(2'b11));
    check("mid_rst dq_oe", 64'(dut.dq_oe), 64'(0));
    check("mid_rst ack", 64'(o_ack), 64'(0));
    exp_q.delete();
    repeat (2) begin
      @(negedge i_clk);
      check("in_rst ack", 64'(o_ack), 64'(0));
    end
    check("in_rst rdata", 64'(o_rdata), 64'(0));
    check("rst no ack", 64'(ack_log.size()), 64'(na));
    idle(1);
    i_rst_n   = 1'b1;
    exp_rdata = '0;
    chk_en    = 1'b1;
    idle(1);
    do_txn("ld_after_rst", 1'b0, 17'h00010, 32'h0, 4'h0, 9, 1'b0);
    check("ld_after_rst rdata", 64'(o_rdata), 64'(32'hDEADBEEF));
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_32b.md
Name: sram_ctrl_32b

Overview:
- Responder side of the LSU-to-SRAM path.
- Accepts one 32-bit load/store request at a time from the memory-stage LSU.
- Serialises each request into two 16-bit asynchronous SRAM accesses (low halfword, then high halfword) on the off-chip 256K x 16 SRAM.
- Returns read data with a one-cycle acknowledge; drives a stall so the pipeline holds the request stable until done.

Parameters:
- ACC_CYC, 2, number of cycles the WE_N/OE_N strobe is held low per halfword access (min 1)
- AW, 17, 32-bit word address width (SRAM halfword address = AW+1 = 18 bits)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_req  in  1  request valid; held stable until o_ack
- i_wren  in  1  1 = store, 0 = load
- i_addr  in  AW  word address
- i_wdata  in  32  store data
- i_bmask  in  4  store byte enables; ignored for loads
- o_rdata  out  32  load data, valid in the o_ack cycle, held until next load completes
- o_ack  out  1  one-cycle completion pulse
- o_stall  out  1  i_req & ~o_ack (combinational)
- o_SRAM_ADDR  out  18  halfword address
- io_SRAM_DQ  inout  16  data bus
- o_SRAM_CE_N, o_SRAM_WE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM controls

Behaviour:
- Reset (async, i_rst_n=0): all SRAM controls =1, ADDR=0, DQ hi-Z, o_rdata=0, o_ack=0, FSM=IDLE. Reset mid-access deasserts strobes immediately.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. A half flag (LO/HI) and a strobe counter (width clog2(ACC_CYC)+1) qualify them.
- IDLE: on i_req, latch addr/wdata/bmask/wren.
  - Load, or store with bmask[1:0]!=0: go to SETUP with half=LO.
  - Store with bmask[1:0]==0 and bmask[3:2]!=0: go to SETUP with half=HI.
  - Store with bmask==0: go to DONE; no SRAM cycle.
- SETUP (1 cycle):
  - ADDR = {addr, half}; CE_N=0; WE_N=OE_N=1.
  - Loads: LB_N=UB_N=0. Stores: LB_N=~mask[even], UB_N=~mask[odd] for the current half.
  - DQ is driven with the current halfword on stores.
- STROBE (ACC_CYC cycles):
  - Store: WE_N=0. Load: OE_N=0.
  - Load: capture DQ into rdata[15:0] (LO) or [31:16] (HI) at the clock edge ending the last STROBE cycle.
- HOLD (1 cycle): strobes high; ADDR, CE_N, byte lanes and store data held.
  - Then, if half=LO and (load or bmask[3:2]!=0): go to SETUP with half=HI.
  - Else: go to DONE.
- DONE (1 cycle): o_ack=1; return to IDLE. i_req is not sampled in DONE.
- DQ is driven only in SETUP/STROBE/HOLD of stores; hi-Z otherwise. OE_N is never low while DQ is driven.
- Latency, with i_req first high in cycle 0, o_ack in cycle N:
  - Load or two-half store: N = 2*(ACC_CYC+2)+1 (9 at default).
  - One-half store: N = ACC_CYC+3 (5 at default).
  - Empty-mask store: N = 1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. No overlap.
- i_req dropping mid-transaction is a protocol violation: the transaction still completes and o_ack still pulses.
- Address wrap: i_addr=all-ones maps to halfwords 0x3FFFE/0x3FFFF. No carry into other regions.
- o_rdata is unchanged by stores.

Decomposition:
- Package sram_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, DONE)
  - SRAM_DW=16, SRAM_AW=18
  - half encoding (LO=0, HI=1)
- One sub-module, sram_io_buf: tristate driver for io_SRAM_DQ, with output enable, output data and input data ports.
- FSM, counter and latches stay in the top module.

Test Plan:
- Store i_addr=0x00010, wdata=0xDEADBEEF, bmask=4'hF:
  - Two write phases: ADDR 0x00020 with DQ 0xBEEF, then ADDR 0x00021 with DQ 0xDEAD.
  - WE_N low 2 cycles per phase; LB_N=UB_N=0; o_ack in cycle 9; o_stall high cycles 0-8.
- Load same address (SRAM model returns the stored data):
  - o_rdata=0xDEADBEEF in the o_ack cycle (cycle 9).
  - OE_N low 2 cycles per phase; DQ never driven by the DUT.
- Store bmask=4'b0100, wdata=0x00AA0000, i_addr=0x1FFFF:
  - Single phase at ADDR 0x3FFFF: LB_N=0, UB_N=1, DQ=0x00AA.
  - o_ack in cycle 5; a following load returns 0x00AAxxxx with the low half unchanged.
- Store bmask=0: no CE_N activity; o_ack in cycle 1; o_rdata unchanged.
- Reset mid-access: assert i_rst_n=0 during the STROBE of a store.
  - WE_N/CE_N return to 1 and DQ to hi-Z in the same cycle; o_ack never pulses.
  - After release, a new load completes normally in 9 cycles.
- Back-to-back store then load, with i_req held high throughout:
  - Two o_ack pulses exactly 10 cycles apart; no cycle with DQ driven while OE_N=0.
